test_signal_gen: RTL and testbench

Multi-channel programmable square/PWM test-signal generator for bench-testing the low-frequency counter and measurement blocks on the board. It replaces the fixed single-period toggle harness. Each channel has a period and high time, both set in microseconds through a write port, with glitch-free updates at period boundaries. It sits at top level, and its outputs drive the measurement input and the board pins.

---
 rtl/siggen_pkg.sv | 30 +++
 rtl/siggen_channel.sv | 141 ++++++++++++++
 rtl/test_signal_gen.sv | 116 +++++++++++
 tb/tb_test_signal_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siggen_pkg.sv
// -----------------------------------------------------------------------------
// siggen_pkg
// Shared definitions for the multi-channel test-signal generator.
//   SIGGEN_PW_DEFAULT : default width of the period / high-time fields (us units)
//   SIGGEN_PW_MAX     : widest field the configuration record can carry
//   siggen_cfg_t      : one channel configuration (period, high), zero-extended
//   check_cfg()       : legality of a (period, high) pair
// -----------------------------------------------------------------------------
package siggen_pkg;

    localparam int SIGGEN_PW_DEFAULT = 25;
    localparam int SIGGEN_PW_MAX     = 32;

    typedef struct packed {
        logic [SIGGEN_PW_MAX-1:0] period;
        logic [SIGGEN_PW_MAX-1:0] high;
    } siggen_cfg_t;

    // A period shorter than 2 us cannot hold both phases, and the high time
    // may not exceed the period it lives in.
    function automatic logic check_cfg(
        input logic [SIGGEN_PW_MAX-1:0] period,
        input logic [SIGGEN_PW_MAX-1:0] high
    );
        logic ok;
        ok = (period >= 32'd2) && (high <= period);
        return ok;
    endfunction

endpackage

// File: rtl/siggen_channel.sv
// -----------------------------------------------------------------------------
// siggen_channel
// One square/PWM channel: active and pending configuration, the us counter,
// and the registered waveform / period-start pulse.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   us_tick                shared 1 us strobe from the prescaler
//   sync_pulse             global phase restart (tied low when not built in)
//   run                    channel enable (level)
//   wr_en                  accepted write addressed to this channel
//   wr_period, wr_high     configuration carried by the write
//   signal                 registered waveform
//   period_tick            one-clock pulse at the start of each period
// -----------------------------------------------------------------------------
module siggen_channel
    import siggen_pkg::*;
#(
    parameter int PW             = SIGGEN_PW_DEFAULT,
    parameter int DEFAULT_PERIOD = 20000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          us_tick,
    input  logic          sync_pulse,
    input  logic          run,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_period,
    input  logic [PW-1:0] wr_high,
    output logic          signal,
    output logic          period_tick
);

    localparam logic [PW-1:0] RST_PERIOD = PW'(DEFAULT_PERIOD);
    localparam logic [PW-1:0] RST_HIGH   = PW'(DEFAULT_PERIOD / 2);

    logic [PW-1:0] act_period_q,  act_period_d;
    logic [PW-1:0] act_high_q,    act_high_d;
    logic [PW-1:0] pend_period_q, pend_period_d;
    logic [PW-1:0] pend_high_q,   pend_high_d;
    logic          pend_valid_q,  pend_valid_d;
    logic [PW-1:0] cnt_q,         cnt_d;
    logic          run_q,         run_d;
    logic          signal_q,      signal_d;
    logic          period_tick_q, period_tick_d;

    logic          start_s;
    logic          wrap_s;
    logic          apply_s;

    // Next-state logic: counter, config hand-over and registered outputs.
    always_comb begin
        act_period_d  = act_period_q;
        act_high_d    = act_high_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        pend_valid_d  = pend_valid_q;
        cnt_d         = cnt_q;
        period_tick_d = 1'b0;
        apply_s       = 1'b0;
        run_d         = run;
        start_s       = run && !run_q;
        wrap_s        = (cnt_q == (act_period_q - PW'(1)));

        // Counter: idle holds zero, sync and run-start restart the phase,
        // otherwise advance on each us strobe and wrap at period-1.
        if (!run) begin
            cnt_d   = {PW{1'b0}};
            apply_s = 1'b1;
        end else if (sync_pulse) begin
            cnt_d         = {PW{1'b0}};
            period_tick_d = 1'b1;
            apply_s       = 1'b1;
        end else if (start_s) begin
            cnt_d         = {PW{1'b0}};
            period_tick_d = 1'b1;
        end else if (us_tick && wrap_s) begin
            cnt_d         = {PW{1'b0}};
            period_tick_d = 1'b1;
            apply_s       = 1'b1;
        end else if (us_tick) begin
            cnt_d = cnt_q + PW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // The old pending config is applied first so that a write landing on
        // the same cycle as a boundary becomes the next pending config.
        if (apply_s && pend_valid_q) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            pend_valid_d = 1'b0;
        end else begin
            act_period_d = act_period_q;
            act_high_d   = act_high_q;
        end

        if (wr_en && !run) begin
            act_period_d = wr_period;
            act_high_d   = wr_high;
        end else if (wr_en) begin
            pend_period_d = wr_period;
            pend_high_d   = wr_high;
            pend_valid_d  = 1'b1;
        end else begin
            pend_period_d = pend_period_q;
            pend_high_d   = pend_high_q;
        end

        // Compare against post-update values so high == period never dips.
        signal_d = run && (cnt_d < act_high_d);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_period_q  <= RST_PERIOD;
            act_high_q    <= RST_HIGH;
            pend_period_q <= {PW{1'b0}};
            pend_high_q   <= {PW{1'b0}};
            pend_valid_q  <= 1'b0;
            cnt_q         <= {PW{1'b0}};
            run_q         <= 1'b0;
            signal_q      <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            act_period_q  <= act_period_d;
            act_high_q    <= act_high_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            pend_valid_q  <= pend_valid_d;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            signal_q      <= signal_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign signal      = signal_q;
    assign period_tick = period_tick_q;

endmodule

// File: rtl/test_signal_gen.sv
// -----------------------------------------------------------------------------
// test_signal_gen
// Multi-channel programmable square/PWM test-signal generator. Period and high
// time are programmed in microseconds; updates to a running channel take effect
// at its next period boundary.
// Optional feature macro: SIGGEN_SYNC_START_EN adds the 'sync' input, a global
// phase restart that realigns every running channel.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en                  one-cycle configuration write strobe
//   wr_ch                  target channel index
//   wr_period, wr_high     period / high time in us
//   run                    per-channel enable (level)
//   sync                   global phase restart (SIGGEN_SYNC_START_EN only)
//   signal                 registered waveforms
//   period_tick            one-clock pulse at the start of each period
//   cfg_err                one-clock pulse when a write is rejected
// -----------------------------------------------------------------------------
module test_signal_gen
    import siggen_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CLK_MHZ        = 50,
    parameter int PW             = SIGGEN_PW_DEFAULT,
    parameter int DEFAULT_PERIOD = 20000
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
    input  logic [PW-1:0]                                   wr_period,
    input  logic [PW-1:0]                                   wr_high,
    input  logic [CHANNELS-1:0]                             run,
`ifdef SIGGEN_SYNC_START_EN
    input  logic                                            sync,
`endif
    output logic [CHANNELS-1:0]                             signal,
    output logic [CHANNELS-1:0]                             period_tick,
    output logic                                            cfg_err
);

    localparam int PSW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PSW-1:0] PRESC_LAST = PSW'(CLK_MHZ - 1);

    logic [PSW-1:0]      presc_q, presc_d;
    logic                cfg_err_q, cfg_err_d;
    logic                us_tick_s;
    logic                sync_s;
    logic                ch_ok_s;
    logic                wr_ok_s;
    siggen_cfg_t         wr_cfg_s;
    logic [CHANNELS-1:0] ch_wr_s;

`ifdef SIGGEN_SYNC_START_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Prescaler: 0..CLK_MHZ-1, strobe on the last count, cleared by sync.
    always_comb begin
        us_tick_s = (presc_q == PRESC_LAST);
        if (sync_s) begin
            presc_d = {PSW{1'b0}};
        end else if (us_tick_s) begin
            presc_d = {PSW{1'b0}};
        end else begin
            presc_d = presc_q + PSW'(1);
        end
    end

    // Write validation and per-channel decode.
    always_comb begin
        wr_cfg_s.period = SIGGEN_PW_MAX'(wr_period);
        wr_cfg_s.high   = SIGGEN_PW_MAX'(wr_high);
        ch_ok_s         = (32'(wr_ch) < 32'(CHANNELS));
        wr_ok_s         = ch_ok_s && check_cfg(wr_cfg_s.period, wr_cfg_s.high);
        cfg_err_d       = wr_en && !wr_ok_s;
        ch_wr_s         = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            ch_wr_s[i] = wr_en && wr_ok_s && (32'(wr_ch) == 32'(i));
        end
    end

    // Prescaler and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= {PSW{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        siggen_channel #(
            .PW             (PW),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .us_tick     (us_tick_s),
            .sync_pulse  (sync_s),
            .run         (run[g]),
            .wr_en       (ch_wr_s[g]),
            .wr_period   (wr_period),
            .wr_high     (wr_high),
            .signal      (signal[g]),
            .period_tick (period_tick[g])
        );
    end

endmodule

// File: tb/tb_test_signal_gen.sv
// -----------------------------------------------------------------------------
// tb_test_signal_gen
// Scoreboard bench: stimulus pushes expected (period, high) measurements and
// expected cfg_err cycles into queues; a negedge monitor measures each output
// period between period_tick pulses and pops/compares.
// A second, 3-channel instance exercises an out-of-range channel index.
// -----------------------------------------------------------------------------
module tb_test_signal_gen;

    localparam int NCH = 4;
    localparam int PW  = 25;

    typedef struct {
        int ch;
        int per;
        int hi;
    } meas_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = 2'd0;
    logic [PW-1:0]  wr_period = '0;
    logic [PW-1:0]  wr_high = '0;
    logic [NCH-1:0] run = '0;
    logic           sync = 1'b0;
    logic [NCH-1:0] signal;
    logic [NCH-1:0] period_tick;
    logic           cfg_err;

    logic           wr3_en = 1'b0;
    logic [1:0]     wr3_ch = 2'd0;
    logic [PW-1:0]  wr3_period = '0;
    logic [PW-1:0]  wr3_high = '0;
    logic [2:0]     run3 = 3'd0;
    logic [2:0]     signal3;
    logic [2:0]     period_tick3;
    logic           cfg_err3;

    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    meas_t exp_q[$];
    int    err_q[$];
    int    err3_q[$];

    test_signal_gen #(
        .CHANNELS(NCH), .CLK_MHZ(2), .PW(PW), .DEFAULT_PERIOD(10)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_period(wr_period), .wr_high(wr_high), .run(run),
`ifdef SIGGEN_SYNC_START_EN
        .sync(sync),
`endif
        .signal(signal), .period_tick(period_tick), .cfg_err(cfg_err)
    );

    test_signal_gen #(
        .CHANNELS(3), .CLK_MHZ(2), .PW(PW), .DEFAULT_PERIOD(10)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr3_en), .wr_ch(wr3_ch),
        .wr_period(wr3_period), .wr_high(wr3_high), .run(run3),
`ifdef SIGGEN_SYNC_START_EN
        .sync(1'b0),
`endif
        .signal(signal3), .period_tick(period_tick3), .cfg_err(cfg_err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: measure periods between ticks, check cfg_err pulses.
    initial begin
        int seen[NCH];
        int last_tick[NCH];
        int hi_cnt[NCH];
        int idx;
        for (int c = 0; c < NCH; c++) begin
            seen[c] = 0; last_tick[c] = 0; hi_cnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int c = 0; c < NCH; c++) seen[c] = 0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (!run[c]) begin
                        seen[c] = 0;
                    end else if (period_tick[c]) begin
                        if (seen[c] >= 2) begin
                            idx = -1;
                            for (int k = 0; k < exp_q.size(); k++)
                                if (idx < 0 && exp_q[k].ch == c) idx = k;
                            if (idx >= 0) begin
                                tests++;
                                if ((cyc - last_tick[c]) != exp_q[idx].per ||
                                    hi_cnt[c] != exp_q[idx].hi) begin
                                    fails++;
                                    $display("FAIL ch%0d_period: got period %0d high %0d, expected period %0d high %0d (cycle %0d)",
                                             c, cyc - last_tick[c], hi_cnt[c],
                                             exp_q[idx].per, exp_q[idx].hi, cyc);
                                end
                                exp_q.delete(idx);
                            end
                        end
                        if (seen[c] < 2) seen[c]++;
                        last_tick[c] = cyc;
                        hi_cnt[c] = signal[c] ? 1 : 0;
                    end else begin
                        hi_cnt[c] += signal[c] ? 1 : 0;
                    end
                end
                if (cfg_err) begin
                    tests++;
                    if (err_q.size() == 0) begin
                        fails++;
                        $display("FAIL cfg_err: got pulse at cycle %0d, expected none", cyc);
                    end else begin
                        if (err_q[0] != cyc) begin
                            fails++;
                            $display("FAIL cfg_err: got pulse at cycle %0d, expected cycle %0d", cyc, err_q[0]);
                        end
                        void'(err_q.pop_front());
                    end
                end
                if (cfg_err3) begin
                    tests++;
                    if (err3_q.size() == 0) begin
                        fails++;
                        $display("FAIL cfg_err3: got pulse at cycle %0d, expected none", cyc);
                    end else begin
                        if (err3_q[0] != cyc) begin
                            fails++;
                            $display("FAIL cfg_err3: got pulse at cycle %0d, expected cycle %0d", cyc, err3_q[0]);
                        end
                        void'(err3_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic expect_meas(input int ch, input int per, input int hi, input int n);
        meas_t m;
        m.ch = ch; m.per = per; m.hi = hi;
        for (int i = 0; i < n; i++) exp_q.push_back(m);
    endtask

    task automatic do_write(input int ch, input int per, input int hi, input bit exp_err);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_ch = 2'(ch); wr_period = PW'(per); wr_high = PW'(hi);
        if (exp_err) err_q.push_back(cyc + 1);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_write3(input int ch, input int per, input int hi, input bit exp_err);
        @(posedge clk); #1;
        wr3_en = 1'b1; wr3_ch = 2'(ch); wr3_period = PW'(per); wr3_high = PW'(hi);
        if (exp_err) err3_q.push_back(cyc + 1);
        @(posedge clk); #1;
        wr3_en = 1'b0;
    endtask

    // Wait until every queued expectation has been consumed, bounded.
    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() + err_q.size() + err3_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if ((exp_q.size() + err_q.size() + err3_q.size()) != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d outstanding expectations, expected 0",
                     name, exp_q.size() + err_q.size() + err3_q.size());
            exp_q.delete();
            err_q.delete();
            err3_q.delete();
        end
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_signal", int'(signal), 0);
        check("rst_period_tick", int'(period_tick), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Defaults on channel 0: 10 us period, 5 us high -> 20 / 10 clocks
        expect_meas(0, 20, 10, 3);
        run = 4'b0001;
        wait_done("t1_default", 400);
        check("t1_others_low", int'(signal[3:1]), 0);

        // Idle write ch1 5/1 then run -> 10 / 2 clocks
        do_write(1, 5, 1, 1'b0);
        expect_meas(1, 10, 2, 3);
        run[1] = 1'b1;
        wait_done("t2_ch1", 400);

        // high = 0 on ch2 -> constant low, ticks every 6 clocks
        do_write(2, 3, 0, 1'b0);
        expect_meas(2, 6, 0, 2);
        run[2] = 1'b1;
        wait_done("t2_high0", 200);
        run[2] = 1'b0;

        // Rejected writes: waveform of ch0 must stay 20/10
        do_write(0, 5, 6, 1'b1);
        do_write(0, 1, 0, 1'b1);
        do_write3(3, 5, 1, 1'b1);
        do_write3(2, 5, 1, 1'b0);
        expect_meas(0, 20, 10, 2);
        wait_done("t4_errors", 400);

        // Mid-period update on running ch0: old period finishes, then 4/4
        repeat (5) @(posedge clk);
        expect_meas(0, 20, 10, 1);
        expect_meas(0, 8, 8, 2);
        do_write(0, 4, 4, 1'b0);
        wait_done("t3_update", 400);

        // Asynchronous reset mid-high-phase
        repeat (3) @(posedge clk);
        #1;
        check("t5_pre_reset_high", int'(signal[0]), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5_reset_signal", int'(signal), 0);
        check("t5_reset_period_tick", int'(period_tick), 0);
        check("t5_reset_cfg_err", int'(cfg_err), 0);
        run = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_meas(0, 20, 10, 2);
        expect_meas(1, 20, 10, 2);
        run = 4'b0011;
        wait_done("t5_defaults", 400);

        // Pending config applied when run deasserts
        do_write(0, 6, 3, 1'b0);
        run[0] = 1'b0;
        @(posedge clk); #1;
        check("t6_run_off_low", int'(signal[0]), 0);
        expect_meas(0, 12, 6, 2);
        run[0] = 1'b1;
        wait_done("t6_deassert_apply", 400);

`ifdef SIGGEN_SYNC_START_EN
        // Global sync realigns channels with different periods
        do_write(2, 3, 2, 1'b0);
        run[2] = 1'b1;
        repeat (37) @(posedge clk);
        #1;
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        check("t7_sync_ticks", int'(period_tick[2:0]), 7);
        check("t7_sync_signals", int'(signal[2:0]), 7);
        expect_meas(0, 12, 6, 1);
        expect_meas(2, 6, 4, 1);
        wait_done("t7_sync", 400);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
